adder_arbiter: RTL
==================

# adder_arbiter

Shares one registered adder datapath among NUM_REQ requesters. Each requester presents operands on a valid/ready handshake. A round-robin arbiter grants one request at a time. The captured operands are summed and registered, and the result is returned on a single response channel tagged with the requester id. The block sits in front of the adder datapath in the multi-adder subsystem and replaces per-requester adder instances.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width
- SWIDTH, WIDTH+1, sum width
- IDW, $clog2(NUM_REQ), id width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_x  in  NUM_REQ*WIDTH  operand x, requester i at bits [i*WIDTH +: WIDTH]
- req_y  in  NUM_REQ*WIDTH  operand y, same packing as req_x
- req_cin  in  NUM_REQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_sum  out  SWIDTH  x + y + cin, zero-extended to SWIDTH
- rsp_zero  out  1  rsp_sum == 0; present only with ADDER_ARB_ZERO_FLAG_EN
- ops_done  out  16  count of completed responses, wraps 0xFFFF -> 0

## Operation
The FSM has three states.
- IDLE
  - req_ready is 0.
  - If any req_valid is set: grant g = first set bit at or after rr_ptr, searching upward with wrap.
  - Assert req_ready[g] combinationally in the same cycle. The transfer occurs on that edge.
  - Capture op_x, op_y, op_cin and id = g. Set rr_ptr = (g+1) mod NUM_REQ. Go to CALC.
- CALC
  - rsp_sum <= op_x + op_y + op_cin, computed at SWIDTH so the carry is kept. rsp_id <= id.
  - Go to RESP.
- RESP
  - rsp_valid = 1. rsp_sum and rsp_id are held stable until accepted.
  - On rsp_valid && rsp_ready, ops_done increments.
  - If any req_valid is set in that same cycle: grant and capture as in IDLE, then go to CALC (back-to-back).
  - Otherwise go to IDLE.
  - Without rsp_ready: stay in RESP; req_ready stays 0.
- Request interface rules:
  - A requester must hold its valid and operands stable until its ready is seen. Dropping valid before ready is legal; that request is simply not granted.
  - req_ready is never asserted for a requester whose req_valid is low.
- Reset values:
  - FSM = IDLE, rr_ptr = 0.
  - rsp_valid, rsp_id, rsp_sum, rsp_zero and ops_done are all 0.
  - req_ready is 0 during reset.
- Reset mid-operation: an in-flight request is dropped with no response. The requester has already seen its ready, so it must not expect a result.

## Timing
- Latency: grant edge to rsp_valid high is 2 cycles (IDLE -> CALC -> RESP).
- Throughput: one result per 2 cycles when rsp_ready is held high and requests are pending.
- Back-pressure: a stall in RESP blocks all new grants. No operand is lost and none is overwritten.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, 2, ..., NUM_REQ-1, 0, ...
- A requester waits at most NUM_REQ grants.
- Simultaneous rsp handshake and new request in RESP: both happen on the same edge.

## Configuration
- ADDER_ARB_ZERO_FLAG_EN defined:
  - The rsp_zero port exists.
  - It is registered in CALC as (op_x + op_y + op_cin) == 0, alongside rsp_sum.
  - It is valid with rsp_valid.
- ADDER_ARB_ZERO_FLAG_EN undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package adder_arb_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CALC, ST_RESP)
  - the ops_done width constant (16)
- Sub-module rr_arbiter:
  - parameter NUM_REQ
  - inputs: req vector, rr_ptr, enable
  - outputs: one-hot grant, grant index, any
- Pointer update and FSM stay in adder_arbiter.

## Test plan
- Reset then single request: req 2 with x=0x05, y=0x03, cin=1 -> req_ready[2] on cycle 0, rsp_valid on cycle 2, rsp_id=2, rsp_sum=0x009, ops_done=1.
- Overflow: x=0xFF, y=0xFF, cin=1 -> rsp_sum=0x1FF.
- Zero case with the flag: x=0, y=0, cin=0 -> rsp_sum=0 and rsp_zero=1 (with ADDER_ARB_ZERO_FLAG_EN).
- All four requesters valid continuously and rsp_ready=1 -> grants 0, 1, 2, 3, 0 at 2-cycle spacing.
  - Responses carry the correct id and sum.
  - ops_done counts 1..5.
- Back-pressure: rsp_ready=0 for 5 cycles while req 1 and req 3 are valid.
  - rsp_valid is held with a stable sum.
  - No req_ready is asserted during the stall.
  - On release, the next grant is on the same edge as the rsp handshake.
- Reset asserted in CALC: all outputs read 0 immediately and no response appears.
  - After release, a new request completes normally.
  - Grants restart at rr_ptr = 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder_arbiter block: FSM state encoding and
// the width of the completed-operation counter.
package adder_arb_pkg;

   // Controller states for the shared adder.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Width of the ops_done counter; it wraps rather than saturates.
   localparam int OPS_DONE_W = 16;

endpackage : adder_arb_pkg

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin grant logic for the shared adder.
// The search starts at rr_ptr and walks upward with wrap. The first set
// request bit found wins. When enable is low nothing is granted, so the
// caller can block grants while a result is still waiting.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     rr_ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_idx,
   output logic               any
);

   int           pos;
   logic [IDW-1:0] pos_idx;

   // Rotating priority search: the first hit at or after rr_ptr wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      pos     = 0;
      pos_idx = '0;
      if (enable) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pos     = (int'(rr_ptr) + i) % NUM_REQ;
            pos_idx = IDW'(pos);
            if (!any && req[pos_idx]) begin
               gnt[pos_idx] = 1'b1;
               gnt_idx      = pos_idx;
               any          = 1'b1;
            end
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one registered adder among NUM_REQ requesters.
// A round-robin arbiter accepts one request at a time. The operands are
// summed one cycle later, and the result is then offered on a single
// response channel tagged with the owner id.
//
// Optional feature: define ADDER_ARB_ZERO_FLAG_EN to add the rsp_zero
// output. It is a registered (sum == 0) flag that is valid with rsp_valid.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no work in flight; grant the next request if any is valid
// CALC    | operands captured; the sum and id are registered this cycle
// RESP    | result offered; on handshake, grant again back-to-back
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int SWIDTH  = WIDTH + 1,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_x,
   input  logic [NUM_REQ*WIDTH-1:0] req_y,
   input  logic [NUM_REQ-1:0]       req_cin,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [SWIDTH-1:0]        rsp_sum,
`ifdef ADDER_ARB_ZERO_FLAG_EN
   output logic                     rsp_zero,
`endif
   output logic [OPS_DONE_W-1:0]    ops_done
);

   state_t               state_q;
   state_t               state_d;
   logic [IDW-1:0]       rr_ptr;

   logic                 arb_en;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IDW-1:0]       arb_idx;
   logic                 arb_any;

   logic [WIDTH-1:0]     sel_x;
   logic [WIDTH-1:0]     sel_y;
   logic                 sel_cin;

   logic [WIDTH-1:0]     op_x;
   logic [WIDTH-1:0]     op_y;
   logic                 op_cin;
   logic [IDW-1:0]       op_id;

   logic [SWIDTH-1:0]    sum_calc;
   logic                 rsp_hs;

   // Grants are allowed only when no result is waiting, or when the
   // waiting result is accepted on this edge. Reset blocks them at once.
   assign arb_en = !rst &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_RESP) && rsp_ready));

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_arbiter (
      .req     (req_valid),
      .rr_ptr  (rr_ptr),
      .enable  (arb_en),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // The grant is one-hot and qualified by req_valid, so it doubles as
   // the ready vector.
   assign req_ready = arb_gnt;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_hs    = rsp_valid && rsp_ready;

   // Steer the granted requester's operands toward the capture registers.
   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_cin = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_x   = req_x[i*WIDTH +: WIDTH];
            sel_y   = req_y[i*WIDTH +: WIDTH];
            sel_cin = req_cin[i];
         end
      end
   end

   // The sum is widened before adding so that the carry out lands in the MSB.
   assign sum_calc = SWIDTH'(op_x) + SWIDTH'(op_y) + SWIDTH'(op_cin);

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = arb_any ? ST_CALC : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register and round-robin pointer. The pointer moves past each winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rr_ptr  <= '0;
      end else begin
         state_q <= state_d;
         if (arb_any) begin
            if (arb_idx == IDW'(NUM_REQ - 1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= arb_idx + IDW'(1);
            end
         end
      end
   end

   // Operand capture on the grant edge. These registers stay untouched
   // until the next grant, so a stalled result cannot be overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_x   <= '0;
         op_y   <= '0;
         op_cin <= 1'b0;
         op_id  <= '0;
      end else if (arb_any) begin
         op_x   <= sel_x;
         op_y   <= sel_y;
         op_cin <= sel_cin;
         op_id  <= arb_idx;
      end
   end

   // Result registers load only in CALC and hold through any RESP stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_sum <= '0;
         rsp_id  <= '0;
      end else if (state_q == ST_CALC) begin
         rsp_sum <= sum_calc;
         rsp_id  <= op_id;
      end
   end

`ifdef ADDER_ARB_ZERO_FLAG_EN
   // The zero flag is computed from the same sum and loads alongside rsp_sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_zero <= 1'b0;
      end else if (state_q == ST_CALC) begin
         rsp_zero <= (sum_calc == '0);
      end
   end
`endif

   // Completed-response counter; it wraps naturally at its width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_done <= '0;
      end else if (rsp_hs) begin
         ops_done <= ops_done + OPS_DONE_W'(1);
      end
   end

endmodule : adder_arbiter
